conv_engine_param: RTL
======================

// Module: conv_engine_param
// PURPOSE
// - Parametrised, self-sequencing convolution engine; successor to the fixed 4x4-image / 3x3-filter engines.
// - Sits between the memory block and the display path.
// - Loads an image and a filter over a streaming write port, then runs a sequential MAC over each output window.
// - Emits saturated results over a valid/ready stream; start/busy/done handshake to the controller.
// - Adds beyond the fixed engines: configurable sizes and stride, output backpressure, saturation reporting.
// PARAMETERS
// DATA_W   8   unsigned width of image and filter words
// IMG_N    4   image is IMG_N x IMG_N
// FLT_K    3   filter is FLT_K x FLT_K; requires FLT_K <= IMG_N
// STRIDE   1   window step; OUT_N = (IMG_N-FLT_K)/STRIDE + 1
// OUT_W    8   result width; accumulator saturates to 2**OUT_W-1
// PORTS
// clk         in   1        single clock, rising edge
// resetn      in   1        asynchronous, active-low reset
// load_valid  in   1        load word present
// load_ready  out  1        engine can accept a load word (1 only in IDLE)
// load_sel    in   1        0 = image buffer, 1 = filter buffer
// load_data   in   DATA_W   word, raster order (row-major)
// start       in   1        begin convolution; sampled in IDLE only
// busy        out  1        high from start acceptance until done
// done        out  1        one-cycle pulse after the last result handshake
// out_valid   out  1        result present
// out_ready   in   1        downstream accepts result
// out_data    out  OUT_W    saturated window sum
// out_row     out  RC_W     output row index; RC_W = max(1,$clog2(OUT_N))
// out_col     out  RC_W     output column index
// sat_flag    out  1        sticky: a result in this run saturated; cleared on start
// BEHAVIOUR
// - Reset (resetn=0, async):
//   - state=IDLE; both buffers and pointers cleared to 0.
//   - Outputs: load_ready=1, busy=0, done=0, out_valid=0, out_data=0, out_row=0, out_col=0, sat_flag=0.
// - Load:
//   - Write occurs on load_valid & load_ready to buffer[load_sel] at its pointer; that pointer then increments.
//   - Image pointer wraps IMG_N^2-1 -> 0; filter pointer wraps FLT_K^2-1 -> 0. Extra words overwrite from index 0.
// - FSM: IDLE -> MAC -> EMIT -> (MAC | FIN) -> IDLE.
//   - IDLE: start=1 -> MAC. Clears acc, sat_flag, window row/col and both load pointers; busy=1, load_ready=0.
//   - MAC: one product per cycle, acc += img[r*STRIDE+i][c*STRIDE+j] * flt[i][j]; i,j raster over FLT_K^2 cycles.
//     - Then -> EMIT with out_data = min(acc, 2**OUT_W-1), out_row=r, out_col=c.
//     - If clamped, sat_flag is set.
//   - EMIT: out_valid=1; out_data/out_row/out_col held stable until out_ready.
//     - On handshake: if more windows (raster, col fastest), advance r/c, clear acc -> MAC; else -> FIN.
//   - FIN: done=1 for one cycle, busy=0 -> IDLE.
// - Latency: first out_valid is FLT_K^2+1 cycles after start is sampled; each following window takes FLT_K^2+1 cycles plus stall time.
// - Arithmetic: ACC_W = 2*DATA_W + $clog2(FLT_K*FLT_K); the accumulator never wraps.
// - Boundaries:
//   - start with incomplete loads: runs on current buffer contents; zeros after reset.
//   - load_valid & start in the same IDLE cycle: the word is written and is visible to the run.
//   - start while busy: ignored. load_valid while busy: not accepted (load_ready=0).
//   - out_ready high outside EMIT: no effect.
//   - resetn low mid-run: immediate IDLE, no done pulse, buffers cleared.
// STRUCTURE
// - Shared package conv_pkg:
//   - FSM state encoding (IDLE, MAC, EMIT, FIN).
//   - acc_w(DATA_W,FLT_K) and out_n(IMG_N,FLT_K,STRIDE) constant functions.
//   - Saturate function.
// - One sub-module conv_mac_unit: multiplier and accumulator with clear/enable, plus saturating output and sat bit.
// - The FSM, address generation and buffers live in the top of this block.
// TESTING
// 1. Defaults. Image all 1, filter all 1, start -> 4 results of 9 at (0,0),(0,1),(1,0),(1,1); done 1 cycle after last handshake.
// 2. Defaults. Image 0..15 raster, filter centre=1 and others 0 -> results 5,6,9,10; first out_valid 10 cycles after start.
// 3. Image all 255, filter all 255 -> every out_data=255, sat_flag=1. Rerun with all-ones data -> sat_flag=0.
// 4. out_ready held low 5 cycles in the first EMIT -> out_valid stays 1 and data/row/col stay stable; no result lost or duplicated.
// 5. IMG_N=5, FLT_K=3, STRIDE=2, image 0..24, filter all 1 -> 2x2 outputs 54,72,144,162 (saturate at 255 not hit).
// 6. resetn pulsed low during the 2nd MAC window -> all outputs at reset values same cycle; a rerun after reload gives the test 1 results.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the parametrised convolution engine.
// - state_t   : engine FSM encoding
// - acc_w     : accumulator width that can never wrap for a K x K window
// - out_n     : output side length for a given image/filter/stride
// - sat_val / is_sat : clamp an accumulator to an OUT_W-bit unsigned range
package conv_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_EMIT, ST_FIN} state_t;

  function automatic int acc_w(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction

  function automatic int out_n(input int n, input int k, input int s);
    return (n - k) / s + 1;
  endfunction

  function automatic logic [63:0] sat_val(input logic [63:0] acc, input int ow);
    logic [63:0] lim;
    lim = (64'd1 << ow) - 64'd1;
    return (acc > lim) ? lim : acc;
  endfunction

  function automatic logic is_sat(input logic [63:0] acc, input int ow);
    return acc > ((64'd1 << ow) - 64'd1);
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Multiply-accumulate unit for one convolution window.
// Ports: clk/resetn; clr zeroes the accumulator (wins over en); en adds a*b;
// sat_data is the accumulator clamped to OUT_W bits, sat_hit flags the clamp.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [OUT_W-1:0]  sat_data,
  output logic              sat_hit
);

  logic [ACC_W-1:0]    acc;
  logic [2*DATA_W-1:0] prod;

  // operands widened first so the full product is kept
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + ACC_W'(prod);
  end

  assign sat_data = OUT_W'(sat_val(64'(acc), OUT_W));
  assign sat_hit  = is_sat(64'(acc), OUT_W);

endmodule

// File: rtl/conv_engine_param.sv
// Self-sequencing convolution engine.
// Loads an IMG_N^2 image and FLT_K^2 filter over a streaming write port
// (load_valid/load_ready/load_sel/load_data, raster order), then on start
// computes one saturated window sum per FLT_K^2+1 cycles and presents it on
// out_valid/out_ready with out_row/out_col. busy covers the run, done pulses
// once after the last result handshake, sat_flag is sticky per run.
module conv_engine_param
  import conv_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int IMG_N  = 4,
  parameter  int FLT_K  = 3,
  parameter  int STRIDE = 1,
  parameter  int OUT_W  = 8,
  localparam int OUT_N  = out_n(IMG_N, FLT_K, STRIDE),
  localparam int RC_W   = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [RC_W-1:0]   out_row,
  output logic [RC_W-1:0]   out_col,
  output logic              sat_flag
);

  localparam int K2    = FLT_K * FLT_K;
  localparam int I2    = IMG_N * IMG_N;
  localparam int IA_W  = (I2 > 1) ? $clog2(I2) : 1;
  localparam int FA_W  = (K2 > 1) ? $clog2(K2) : 1;
  localparam int KW    = (FLT_K > 1) ? $clog2(FLT_K) : 1;
  localparam int CW    = $clog2(K2 + 1);
  localparam int ACC_W = acc_w(DATA_W, FLT_K);

  state_t state, nstate;

  logic [DATA_W-1:0] img_buf [I2];
  logic [DATA_W-1:0] flt_buf [K2];
  logic [IA_W-1:0]   img_ptr, img_addr;
  logic [FA_W-1:0]   flt_ptr, flt_addr;
  logic [CW-1:0]     k;
  logic [KW-1:0]     fi, fj;
  logic [RC_W-1:0]   win_r, win_c;
  logic              mac_last, last_win, mac_clr, mac_en, sat_hit;
  logic [OUT_W-1:0]  sat_data;

  // k runs 0..K2: K2 accumulate cycles plus one cycle to latch the sum
  assign mac_last = (k == CW'(K2));
  assign last_win = (win_r == RC_W'(OUT_N - 1)) && (win_c == RC_W'(OUT_N - 1));
  assign mac_clr  = (state == ST_IDLE && start) || (state == ST_EMIT && out_ready);
  assign mac_en   = (state == ST_MAC) && !mac_last;

  assign img_addr = IA_W'((int'(win_r) * STRIDE + int'(fi)) * IMG_N
                          + int'(win_c) * STRIDE + int'(fj));
  assign flt_addr = mac_last ? '0 : FA_W'(k);

  // Buffers and load pointers. A start in the same cycle as a load keeps the
  // written word but rewinds both pointers for the next load session.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < I2; n++) img_buf[n] <= '0;
      for (int n = 0; n < K2; n++) flt_buf[n] <= '0;
      img_ptr <= '0;
      flt_ptr <= '0;
    end else begin
      if (load_valid && load_ready) begin
        if (load_sel) begin
          flt_buf[flt_ptr] <= load_data;
          flt_ptr <= (flt_ptr == FA_W'(K2 - 1)) ? '0 : flt_ptr + FA_W'(1);
        end else begin
          img_buf[img_ptr] <= load_data;
          img_ptr <= (img_ptr == IA_W'(I2 - 1)) ? '0 : img_ptr + IA_W'(1);
        end
      end
      if (state == ST_IDLE && start) begin
        img_ptr <= '0;
        flt_ptr <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (start)    nstate = ST_MAC;
      ST_MAC:  if (mac_last) nstate = ST_EMIT;
      ST_EMIT: if (out_ready) nstate = last_win ? ST_FIN : ST_MAC;
      ST_FIN:  nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: load_ready = 1'b1;
      ST_MAC:  busy = 1'b1;
      ST_EMIT: begin busy = 1'b1; out_valid = 1'b1; end
      ST_FIN:  done = 1'b1;
      default: load_ready = 1'b0;
    endcase
  end

  // Window sequencing and result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      k <= '0; fi <= '0; fj <= '0;
      win_r <= '0; win_c <= '0;
      out_data <= '0; out_row <= '0; out_col <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          k <= '0; fi <= '0; fj <= '0;
          win_r <= '0; win_c <= '0;
          sat_flag <= 1'b0;
        end
        ST_MAC: if (mac_last) begin
          out_data <= sat_data;
          out_row  <= win_r;
          out_col  <= win_c;
          if (sat_hit) sat_flag <= 1'b1;
          k <= '0;
        end else begin
          k <= k + CW'(1);
          // fi/fj wrap back to 0 on the final product, ready for the next window
          if (fj == KW'(FLT_K - 1)) begin
            fj <= '0;
            fi <= (fi == KW'(FLT_K - 1)) ? '0 : fi + KW'(1);
          end else begin
            fj <= fj + KW'(1);
          end
        end
        ST_EMIT: if (out_ready && !last_win) begin
          if (win_c == RC_W'(OUT_N - 1)) begin
            win_c <= '0;
            win_r <= win_r + RC_W'(1);
          end else begin
            win_c <= win_c + RC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  conv_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) u_mac (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (mac_clr),
    .en       (mac_en),
    .a        (img_buf[img_addr]),
    .b        (flt_buf[flt_addr]),
    .sat_data (sat_data),
    .sat_hit  (sat_hit)
  );

endmodule
